fir_coef_ctrl: RTL and testbench

//  Coefficient controller/scheduler for the 4-tap transposed FIR (mu/de/ad datapath).

---
 rtl/fir_coef_ctrl_if.sv | 39 +++
 rtl/fir_coef_ctrl.sv | 109 ++++++++++
 tb/tb_fir_coef_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_ctrl_if.sv
// Coefficient-controller bus: cfg writes/commit and sample strobe in, coefs and status out.
// Readback ports exist only when FIR_COEF_READBACK_EN is defined.
interface fir_coef_ctrl_if #(
    parameter int NTAPS = 4,
    parameter int DW    = 8,
    parameter int AW    = 2
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [AW-1:0]       cfg_addr;
    logic [DW-1:0]       cfg_data;
    logic                cfg_commit;
    logic                in_valid;
    logic [NTAPS*DW-1:0] coef_bus;
    logic                out_valid;
    logic                busy;
`ifdef FIR_COEF_READBACK_EN
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       rd_data;
`endif

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_commit, in_valid,
`ifdef FIR_COEF_READBACK_EN
        output rd_addr,
        input  rd_data,
`endif
        input  cfg_ready, coef_bus, out_valid, busy
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_commit, in_valid,
`ifdef FIR_COEF_READBACK_EN
        input  rd_addr,
        output rd_data,
`endif
        output cfg_ready, coef_bus, out_valid, busy
    );
endinterface

// File: rtl/fir_coef_ctrl.sv
// FIR coefficient shadow/active controller; out_valid 1-cycle latency, cfg writes stalled while a commit is armed.
// FIR_COEF_READBACK_EN adds a 1-cycle active-coefficient readback port.
module fir_coef_ctrl #(
    parameter int            NTAPS    = 4,
    parameter int            DW       = 8,
    parameter int            AW       = 2,
    parameter logic [DW-1:0] COEF_RST = DW'(1)
) (
    input  logic              clk,
    input  logic              reset,
    fir_coef_ctrl_if.slave    bus
);
    localparam int CW = (NTAPS > 2) ? $clog2(NTAPS - 1) : 1;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(NTAPS - 2);

    typedef enum logic [1:0] {IDLE, ARM, SETTLE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic            out_valid_q, out_valid_d;
    logic            swap_now;
    logic            wr_en;
    logic [DW-1:0]   shadow_q [NTAPS];
    logic [DW-1:0]   active_q [NTAPS];

    assign bus.cfg_ready = (state_q != ARM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign wr_en         = bus.cfg_valid && bus.cfg_ready;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        swap_now = 1'b0;
        if (bus.in_valid && (settle_q != '0)) begin
            settle_d = settle_q - CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.cfg_commit) state_d = ARM;
            end
            ARM: begin
                // Swap lands on the first sample after the commit, never on the commit edge.
                if (bus.in_valid) begin
                    swap_now = 1'b1;
                    settle_d = SETTLE_INIT;
                    state_d  = (NTAPS > 2) ? SETTLE : IDLE;
                end
            end
            SETTLE: begin
                if (bus.in_valid && (settle_q == CW'(1))) state_d = IDLE;
                if (bus.cfg_commit) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = bus.in_valid && !swap_now && (settle_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= COEF_RST;
                active_q[i] <= COEF_RST;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (wr_en && (bus.cfg_addr == AW'(i))) shadow_q[i] <= bus.cfg_data;
                if (swap_now) active_q[i] <= shadow_q[i];
            end
        end
    end

    always_comb begin
        bus.coef_bus = '0;
        for (int i = 0; i < NTAPS; i++) begin
            bus.coef_bus[(NTAPS-1-i)*DW +: DW] = active_q[i];
        end
    end

`ifdef FIR_COEF_READBACK_EN
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (bus.rd_addr == AW'(i)) rd_data_d = active_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: directed vector table, reset-while-armed sequence, then
// randomized traffic against a sample-counting reference model.
module tb_fir_coef_ctrl;
    localparam int NTAPS = 4;
    localparam int DW    = 8;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fir_coef_ctrl_if #(.NTAPS(NTAPS), .DW(DW), .AW(AW)) bus ();

    fir_coef_ctrl #(.NTAPS(NTAPS), .DW(DW), .AW(AW), .COEF_RST(8'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic [7:0]  d;
        logic        cm;
        logic        iv;
        logic        e_rdy;
        logic        e_busy;
        logic        e_ov;
        logic [31:0] e_bus;
    } vec_t;

    vec_t tbl [27];

    // Reference model: shadow/active sets, pending commit, masked samples still owed.
    logic [7:0] m_sh  [NTAPS];
    logic [7:0] m_act [NTAPS];
    logic       m_pend;
    int         m_rem;
    logic       m_ov;
    logic [7:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] a, input logic [7:0] d,
                         input logic cm, input logic iv);
        @(negedge clk);
        bus.cfg_valid  = v;
        bus.cfg_addr   = a;
        bus.cfg_data   = d;
        bus.cfg_commit = cm;
        bus.in_valid   = iv;
        #1;
    endtask

    function automatic logic [31:0] model_bus();
        return {m_act[0], m_act[1], m_act[2], m_act[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_sh[i]  = 8'd1;
            m_act[i] = 8'd1;
        end
        m_pend = 1'b0;
        m_rem  = 0;
        m_ov   = 1'b0;
        m_rd   = 8'd0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] a, input logic [7:0] d,
                              input logic cm, input logic iv, input logic [1:0] ra);
        logic was_pend;
        was_pend = m_pend;
        m_ov = iv && !m_pend && (m_rem == 0);
        m_rd = (int'(ra) < NTAPS) ? m_act[ra] : 8'd0;
        if (iv) begin
            if (m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
                m_rem  = NTAPS - 2;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        if (v && !was_pend) m_sh[a] = d;
        if (cm && !was_pend) m_pend = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v  a     d     cm iv  rdy busy ov  bus
        tbl[0]  = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  0, 32'h01010101};
        tbl[1]  = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  1, 32'h01010101};
        tbl[2]  = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  1, 32'h01010101};
        tbl[3]  = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  1, 32'h01010101};
        tbl[4]  = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  1, 32'h01010101};
        tbl[5]  = '{1, 2'd0, 8'd2, 0, 0,  1,  0,  1, 32'h01010101};
        tbl[6]  = '{1, 2'd1, 8'd3, 0, 0,  1,  0,  0, 32'h01010101};
        tbl[7]  = '{1, 2'd2, 8'd4, 0, 0,  1,  0,  0, 32'h01010101};
        tbl[8]  = '{1, 2'd3, 8'd5, 0, 0,  1,  0,  0, 32'h01010101};
        tbl[9]  = '{0, 2'd0, 8'd0, 1, 0,  1,  0,  0, 32'h01010101};
        tbl[10] = '{0, 2'd0, 8'd0, 0, 0,  0,  1,  0, 32'h01010101};
        tbl[11] = '{0, 2'd0, 8'd0, 0, 1,  0,  1,  0, 32'h01010101};
        tbl[12] = '{0, 2'd0, 8'd0, 0, 1,  1,  1,  0, 32'h02030405};
        tbl[13] = '{0, 2'd0, 8'd0, 0, 1,  1,  1,  0, 32'h02030405};
        tbl[14] = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  0, 32'h02030405};
        tbl[15] = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  1, 32'h02030405};
        tbl[16] = '{1, 2'd2, 8'd9, 1, 0,  1,  0,  1, 32'h02030405};
        tbl[17] = '{1, 2'd0, 8'd7, 0, 0,  0,  1,  0, 32'h02030405};
        tbl[18] = '{0, 2'd0, 8'd0, 0, 1,  0,  1,  0, 32'h02030405};
        tbl[19] = '{0, 2'd0, 8'd0, 0, 1,  1,  1,  0, 32'h02030905};
        tbl[20] = '{0, 2'd0, 8'd0, 0, 0,  1,  1,  0, 32'h02030905};
        tbl[21] = '{0, 2'd0, 8'd0, 1, 0,  1,  1,  0, 32'h02030905};
        tbl[22] = '{0, 2'd0, 8'd0, 0, 1,  0,  1,  0, 32'h02030905};
        tbl[23] = '{0, 2'd0, 8'd0, 0, 1,  1,  1,  0, 32'h02030905};
        tbl[24] = '{0, 2'd0, 8'd0, 0, 1,  1,  1,  0, 32'h02030905};
        tbl[25] = '{0, 2'd0, 8'd0, 0, 1,  1,  0,  0, 32'h02030905};
        tbl[26] = '{0, 2'd0, 8'd0, 0, 0,  1,  0,  1, 32'h02030905};

        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;
        bus.in_valid   = 1'b0;
`ifdef FIR_COEF_READBACK_EN
        bus.rd_addr    = 2'd3;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("reset_coef_bus", bus.coef_bus, 32'h01010101);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef FIR_COEF_READBACK_EN
        chk("reset_rd_data", {24'd0, bus.rd_data}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].cm, tbl[i].iv);
            chk($sformatf("row%0d_cfg_ready", i), {31'd0, bus.cfg_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d_busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("row%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("row%0d_coef_bus", i), bus.coef_bus, tbl[i].e_bus);
        end

`ifdef FIR_COEF_READBACK_EN
        // Readback follows the active set (c3=5, c2=9), one cycle behind rd_addr.
        bus.rd_addr = 2'd3;
        apply(0, 2'd0, 8'd0, 0, 0);
        chk("rd_c3", {24'd0, bus.rd_data}, 32'd5);
        bus.rd_addr = 2'd2;
        apply(0, 2'd0, 8'd0, 0, 0);
        chk("rd_c2", {24'd0, bus.rd_data}, 32'd9);
        bus.rd_addr = 2'd3;
`endif

        // Reset pulse while a commit is armed with new shadow contents.
        apply(1, 2'd1, 8'h44, 1, 0);
        apply(0, 2'd0, 8'd0, 0, 0);
        chk("arm_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_arm_coef_bus", bus.coef_bus, 32'h01010101);
        chk("rst_arm_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_arm_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
`ifdef FIR_COEF_READBACK_EN
        chk("rst_arm_rd_data", {24'd0, bus.rd_data}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_coef_bus", bus.coef_bus, 32'h01010101);

        // Randomized traffic against the reference model.
        model_reset();
        m_rd = 8'd1;
        for (int n = 0; n < 600; n++) begin
            logic       v, cm, iv;
            logic [1:0] a, ra;
            logic [7:0] d;
            v  = ($urandom_range(0, 1) == 1);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            cm = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 9) < 6);
            ra = 2'($urandom_range(0, 3));
`ifdef FIR_COEF_READBACK_EN
            bus.rd_addr = ra;
`endif
            apply(v, a, d, cm, iv);
            chk("rnd_cfg_ready", {31'd0, bus.cfg_ready}, {31'd0, !m_pend});
            chk("rnd_busy", {31'd0, bus.busy}, {31'd0, (m_pend || m_rem > 0)});
            chk("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
            chk("rnd_coef_bus", bus.coef_bus, model_bus());
`ifdef FIR_COEF_READBACK_EN
            chk("rnd_rd_data", {24'd0, bus.rd_data}, {24'd0, m_rd});
`endif
            model_step(v, a, d, cm, iv, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
